reg_debug_port: RTL and testbench

Debug-side initiator for the 32x32 register file. It accepts single-register read, single-register write and full-dump commands over a valid/ready command channel. It drives the register file's read address and write port while the core is halted, and returns results over a valid/ready response channel. It sits between the debug transport and the register file's spare read port and the write-port mux.

---
 rtl/reg_debug_port.sv | 138 +++++++++++++
 tb/tb_reg_debug_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_debug_port.sv
// Debug-side register file initiator: single read/write and full dump commands,
// gated on core halt, with results returned over a valid/ready response channel.
module reg_debug_port #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  input  logic            core_halted,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_wr,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_addr,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_HALT, S_READ, S_WRITE, S_RSP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      addr;
    logic            last;
    logic            err;
  } rsp_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t          state, state_n;
  logic [1:0]      op, op_n;
  logic [4:0]      idx, idx_n;
  logic [XLEN-1:0] wdata, wdata_n;
  rsp_t            rsp, rsp_n;
  logic            rf_wr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= OP_RD;
      idx   <= '0;
      wdata <= '0;
      rsp   <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      idx   <= idx_n;
      wdata <= wdata_n;
      rsp   <= rsp_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    idx_n   = idx;
    wdata_n = wdata;
    rsp_n   = rsp;
    rf_wr_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n    = cmd_op;
          wdata_n = cmd_wdata;
          idx_n   = (cmd_op == OP_DUMP) ? 5'd0 : cmd_addr;
          if (cmd_op == OP_ILL) begin
            rsp_n   = '{data: '0, addr: cmd_addr, last: 1'b1, err: 1'b1};
            state_n = S_RSP;
          end else begin
            state_n = S_WAIT_HALT;
          end
        end
      end
      S_WAIT_HALT: begin
        if (core_halted) state_n = (op == OP_WR) ? S_WRITE : S_READ;
      end
      S_READ: begin
        // A halt drop here discards the sample; the same idx is retried later.
        if (core_halted) begin
          rsp_n   = '{data: rf_rdata, addr: idx,
                      last: (op == OP_RD) || (idx == LAST_IDX), err: 1'b0};
          state_n = S_RSP;
        end else begin
          state_n = S_WAIT_HALT;
        end
      end
      S_WRITE: begin
        if (core_halted) begin
          rf_wr_c = (idx != 5'd0);
          rsp_n   = '{data: wdata, addr: idx, last: 1'b1, err: 1'b0};
          state_n = S_RSP;
        end else begin
          state_n = S_WAIT_HALT;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          if (rsp.last) begin
            state_n = S_IDLE;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = core_halted ? S_READ : S_WAIT_HALT;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake-visible outputs are forced quiet during the reset cycle itself.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RSP) && !rst;
  assign busy      = (state != S_IDLE) && !rst;
  assign rf_wr     = rf_wr_c && !rst;

  assign rf_raddr  = idx;
  assign rf_waddr  = idx;
  assign rf_wdata  = wdata;
  assign rsp_data  = rsp.data;
  assign rsp_addr  = rsp.addr;
  assign rsp_last  = rsp.last;
  assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_reg_debug_port.sv
// Scoreboarded bench for reg_debug_port: stimulus pushes expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_reg_debug_port;
  localparam int NREGS = 32;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            core_halted;
  logic [4:0]      rf_raddr, rf_waddr, rsp_addr;
  logic [XLEN-1:0] rf_rdata, rf_wdata, rsp_data;
  logic            rf_wr, rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
  logic            preload;

  always #5 clk = ~clk;

  reg_debug_port #(.NREGS(NREGS), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .core_halted(core_halted),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_wr(rf_wr),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
  );

  // Register file stand-in; writes x0 too, so a stray x0 write is visible.
  logic [XLEN-1:0] regs [NREGS];
  assign rf_rdata = regs[rf_raddr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == 0) ? '0 : XLEN'(32'h100 + i);
    end else if (rf_wr) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            last;
    logic            err;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, rsp_cnt = 0, wr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [XLEN-1:0] d,
                          input logic l, input logic e);
    exp_t x;
    x.addr = a; x.data = d; x.last = l; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic push_dump();
    for (int i = 0; i < NREGS; i++)
      push_exp(5'(i), (i == 0) ? '0 : XLEN'(32'h100 + i), i == NREGS - 1, 1'b0);
  endtask

  // Monitor: response scoreboard, hold-stability and rf_wr pulse counting.
  initial begin
    logic            hold;
    logic [XLEN-1:0] h_data;
    logic [4:0]      h_addr;
    logic            h_last, h_err;
    exp_t            e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_wr) wr_cnt++;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(rsp_valid), 64'd1);
          chk("hold_fields", {rsp_addr, rsp_data, rsp_last, rsp_err},
              {h_addr, h_data, h_last, h_err});
        end
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got addr %0d data %0h, expected none", rsp_addr, rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_last", 64'(rsp_last), 64'(e.last));
            chk("rsp_err",  64'(rsp_err),  64'(e.err));
          end
        end
        hold   = rsp_valid && !rsp_ready;
        h_data = rsp_data; h_addr = rsp_addr; h_last = rsp_last; h_err = rsp_err;
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge; returns in cycle N+1.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [XLEN-1:0] d);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL cmd_accept_timeout: got ready 0, expected 1"); end
  endtask

  task automatic wait_idle(input bit toggle);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      @(posedge clk); #1;
      if (toggle) rsp_ready = ~rsp_ready;
    end
    if (!ok) begin total++; bad++; $display("FAIL idle_timeout: got busy 1, expected 0"); end
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, r0;
    bit found;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    core_halted = 1'b1; rsp_ready = 1'b1; preload = 1'b1;

    // Reset behaviour
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rf_wr", 64'(rf_wr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_rsp", {rsp_addr, rsp_data, rsp_last, rsp_err}, 64'd0);
    @(posedge clk); #1;

    // Write x5 with latency check
    w0 = wr_cnt;
    push_exp(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    send_cmd(2'b01, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_n1_rf_wr", 64'(rf_wr), 64'd0);
    @(negedge clk);
    chk("wr_n2_rf_wr", 64'(rf_wr), 64'd1);
    chk("wr_n2_waddr", 64'(rf_waddr), 64'd5);
    chk("wr_n2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("wr_n3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_n3_rf_wr", 64'(rf_wr), 64'd0);
    @(posedge clk); #1;
    wait_idle(1'b0);
    chk("wr_pulses", 64'(wr_cnt - w0), 64'd1);

    // Read back x5
    push_exp(5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd5, '0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_n2_raddr", 64'(rf_raddr), 64'd5);
    chk("rd_n2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("rd_n3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_n3_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    @(posedge clk); #1;
    wait_idle(1'b0);

    // Write to x0 is swallowed, then x0 reads as 0
    w0 = wr_cnt;
    push_exp(5'd0, 32'h1234, 1'b1, 1'b0);
    send_cmd(2'b01, 5'd0, 32'h1234);
    wait_idle(1'b0);
    chk("x0_no_wr", 64'(wr_cnt - w0), 64'd0);
    push_exp(5'd0, 32'h0, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd0, '0);
    wait_idle(1'b0);

    // Dump with rsp_ready toggling
    preload = 1'b1; @(posedge clk); #1; preload = 1'b0;
    r0 = rsp_cnt;
    push_dump();
    rsp_ready = 1'b0;
    send_cmd(2'b10, 5'd17, '0);
    wait_idle(1'b1);
    rsp_ready = 1'b1;
    chk("dump_toggle_count", 64'(rsp_cnt - r0), 64'd32);

    // Command issued while core running; halt arrives 10 cycles later
    core_halted = 1'b0;
    r0 = rsp_cnt; w0 = wr_cnt;
    push_exp(5'd3, 32'h103, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd3, '0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("nohalt_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    chk("nohalt_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    core_halted = 1'b1;
    wait_idle(1'b0);
    chk("halt_rsp_count", 64'(rsp_cnt - r0), 64'd1);
    chk("halt_no_wr", 64'(wr_cnt - w0), 64'd0);

    // Dump with halt dropped for 5 cycles at idx 7
    r0 = rsp_cnt;
    push_dump();
    send_cmd(2'b10, 5'd0, '0);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_addr == 5'd7) begin found = 1; break; end
    end
    chk("dump_reach_idx7", 64'(found), 64'd1);
    core_halted = 1'b0;
    repeat (5) @(posedge clk);
    #1 core_halted = 1'b1;
    wait_idle(1'b0);
    chk("dump_halt_count", 64'(rsp_cnt - r0), 64'd32);

    // Illegal opcode
    w0 = wr_cnt;
    push_exp(5'd9, 32'h0, 1'b1, 1'b1);
    send_cmd(2'b11, 5'd9, 32'hCAFE);
    wait_idle(1'b0);
    chk("ill_no_wr", 64'(wr_cnt - w0), 64'd0);

    // Reset while holding the first dump response
    rsp_ready = 1'b0;
    send_cmd(2'b10, 5'd0, '0);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1; break; end
    end
    chk("rstdump_rsp_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstdump_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstdump_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstdump_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rstdump_idle_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    push_exp(5'd5, 32'h105, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd5, '0);
    wait_idle(1'b0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
